dual_phase_sig_gen: RTL and testbench
=====================================

// Module: dual_phase_sig_gen
// PURPOSE
//  Two-channel sine generator, the stimulus source for phase_diff measurement.
//  signal_2 is offset from signal_1 by a programmable phase, in phase_diff units.
//  Feeds the correlation phase measurer in loopback/self-test and drives the DAC path in bench mode.
//  Sample index runs 0..N-1 per period; signal_1 is sin(2*pi*idx/N).
// PARAMETERS
//  N       1024  samples per period (power of 2, >=16)
//  OUT_W   12    output sample width, signed
//  PH_W    16    phase word width; a full period is 32768 counts
// PORTS
//  clk          in   1      clock
//  rst          in   1      synchronous reset, active-high
//  en           in   1      advance sample index this cycle
//  cfg_phase    in   PH_W   signed phase of signal_2 relative to signal_1; negative = signal_1 leads
//  cfg_valid    in   1      cfg_phase offered
//  cfg_ready    out  1      high = no update pending
//  signal_1     out  OUT_W  signed reference channel
//  signal_2     out  OUT_W  signed phase-shifted channel
//  sample_valid out  1      signal_1/signal_2 updated this cycle
//  frame_start  out  1      pulse aligned with the output sample for idx==0
// BEHAVIOUR
//  Reset: idx=0, active offset=0, pending=0, pipeline valids=0; all outputs 0; cfg_ready=1 on the first cycle after reset.
//  Index: idx <= (idx+1) mod N when en. Wrap N-1 -> 0 is silent.
//  Offset: off = (cfg_phase * N) >> 15, truncated mod N (two's complement wraps naturally). For N=1024 this is cfg_phase[14:5].
//    Example: 8192 -> 256. -8192 -> 768.
//  Channel 2 index: idx2 = (idx + off) mod N.
//  Handshake:
//    Accept when cfg_valid && cfg_ready; the value goes to the pending register, and cfg_ready drops the next cycle.
//    Pending becomes active on the cycle idx wraps N-1 -> 0 with en=1, so a frame never mixes offsets.
//    If en=0, pending becomes active on the next cycle.
//    A word accepted in the same cycle as a wrap is applied at the following wrap; no bypass.
//    cfg_ready returns to 1 the cycle after the pending word becomes active.
//  Pipeline, 3 stages. Each stage has a valid bit that travels with en. Output registers load only when stage-3 valid=1, otherwise they hold.
//    S1: register quadrant q = idx[MSB:MSB-1] and a = idx mod N/4, for both channels. frame_start tag = (idx==0).
//    S2: LUT read (registered). Read address is a for q0/q2 and N/4-a for q1/q3. The a==0 case in q1/q3 selects the constant FULL = 2^(OUT_W-1)-1.
//    S3: negate for q2/q3, then register outputs. sample_valid = S3 valid. frame_start = S3 tag && S3 valid.
//  Latency: 3 cycles from an index update to sample_valid.
//  LUT contents: round(FULL*sin(2*pi*k/N)), k=0..N/4-1. All values are in [0,FULL]; negation never overflows.
//  rst mid-frame: everything returns to reset state in 1 cycle, and pending cfg is discarded.
//  A held cfg_valid while cfg_ready=0 is not accepted; the source must hold its value.
// CONFIGURATION
//  DPSG_AMP2_SCALE_EN defined:
//    Adds input port cfg_amp2 [7:0] (unsigned gain, 256 = 1.0). It is latched with cfg_phase, using the same pending/apply rules.
//    At S3, signal_2 = (s2 * cfg_amp2) >>> 8, with arithmetic shift (truncation toward -inf). Reset gain = 255.
//  Undefined: no cfg_amp2 port; signal_2 is unscaled.
// STRUCTURE
//  Package dpsg_pkg holds:
//    PH_FULL = 32768; quadrant encoding localparams Q0..Q3.
//    function ph_to_off(phase, N); function fold_addr(a, q).
//  Sub-module sine_qlut (registered quarter-wave ROM, N/4 x (OUT_W-1) unsigned). Two instances, one per channel.
// TESTING
//  rst=1 then en=1 -> first sample_valid 3 cycles after en, with frame_start=1 and signal_1=0, signal_2=0 (phase 0).
//  cfg_phase=0 -> signal_1==signal_2 every valid cycle; peak +2047 at idx=256, -2047 at idx=768.
//  cfg_phase=8192 -> at frame_start signal_1=0, signal_2=+2047. cfg_phase=-8192 -> signal_2=-2047.
//  cfg_phase=4096 accepted at idx=100 -> cfg_ready low; samples 101..1023 keep the old offset; new offset (128) starts at the next frame_start; cfg_ready high one cycle later.
//  en toggled 1/0 each cycle -> the index advances only on en cycles, sample_valid follows with 3-cycle latency, outputs hold in between.
//  rst pulse mid-frame with a pending cfg -> outputs 0, cfg_ready=1, the pending value is not applied.
//  (DPSG_AMP2_SCALE_EN) cfg_amp2=128, phase 0 -> signal_2 peak +1023, trough -1024.

Source files
------------

// File: rtl/dpsg_pkg.sv
// dpsg_pkg: shared constants and index helpers for dual_phase_sig_gen
package dpsg_pkg;
    localparam int PH_FULL = 32768;
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    // floor(phase * n / PH_FULL) mod n; n is a power of 2 so the mask wraps negatives
    function automatic int ph_to_off(input int phase, input int n);
        return ((phase * n) >>> $clog2(PH_FULL)) & (n - 1);
    endfunction

    // Falling quadrants read the table backwards; caller truncates to the ROM width
    function automatic int fold_addr(input int a, input logic [1:0] q);
        return (q == Q0 || q == Q2) ? a : -a;
    endfunction
endpackage

// File: rtl/sine_qlut.sv
// sine_qlut: registered quarter-wave ROM holding round(FULL*sin(2*pi*k/N)), k < N/4
module sine_qlut
    import dpsg_pkg::*;
#(
    parameter int N     = 1024,
    parameter int OUT_W = 12
) (
    input  logic                     clk,
    input  logic [$clog2(N/4)-1:0]   addr,
    output logic [OUT_W-2:0]         data
);
    localparam int  QN  = N / 4;
    localparam real PI  = 3.141592653589793;
    localparam real AMP = real'(2 ** (OUT_W - 1) - 1);

    logic [OUT_W-2:0] w_rom [QN];

    for (genvar k = 0; k < QN; k++) begin : g_rom
        localparam int V = $rtoi(AMP * $sin(2.0 * PI * k / N) + 0.5);
        assign w_rom[k] = (OUT_W-1)'(V);
    end

    always_ff @(posedge clk) data <= w_rom[addr];
endmodule

// File: rtl/dual_phase_sig_gen.sv
// dual_phase_sig_gen: two-channel sine source, signal_2 offset by a frame-aligned programmable phase
// Define DPSG_AMP2_SCALE_EN to add the cfg_amp2 gain on signal_2.
module dual_phase_sig_gen
    import dpsg_pkg::*;
#(
    parameter int N     = 1024,
    parameter int OUT_W = 12,
    parameter int PH_W  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [PH_W-1:0]  cfg_phase,
    input  logic                    cfg_valid,
`ifdef DPSG_AMP2_SCALE_EN
    input  logic [7:0]              cfg_amp2,
`endif
    output logic                    cfg_ready,
    output logic signed [OUT_W-1:0] signal_1,
    output logic signed [OUT_W-1:0] signal_2,
    output logic                    sample_valid,
    output logic                    frame_start
);
    localparam int IW = $clog2(N);
    localparam int AW = IW - 2;
    localparam logic signed [OUT_W-1:0] FULL = OUT_W'(2 ** (OUT_W - 1) - 1);

    logic [IW-1:0]          r_idx;
    logic signed [PH_W-1:0] r_phase;
    logic signed [PH_W-1:0] r_pend;
    logic                   r_pend_v;
    logic                   r_applied;
    logic                   r_v1;
    logic                   r_v2;
    logic                   r_t1;
    logic                   r_t2;
    logic [IW-1:0]          w_off;
    logic                   w_apply;
    logic [1:0][OUT_W-1:0]  w_o;
    logic [OUT_W-1:0]       w_s2;

    assign w_off     = IW'(ph_to_off(int'(r_phase), N));
    assign w_apply   = r_pend_v && (!en || r_idx == IW'(N - 1));
    assign cfg_ready = !(r_pend_v || r_applied);

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic [IW-1:0]           w_ix;
        logic [AW-1:0]           w_addr;
        logic [OUT_W-2:0]        w_lut;
        logic signed [OUT_W-1:0] w_s;
        logic [1:0]              r_q1;
        logic [1:0]              r_q2;
        logic [AW-1:0]           r_a1;
        logic                    r_f2;
        assign w_ix   = r_idx + (c == 1 ? w_off : '0);
        assign w_addr = AW'(fold_addr(int'(r_a1), r_q1));
        always_ff @(posedge clk) begin
            if (rst) begin
                r_q1 <= '0;
                r_a1 <= '0;
                r_q2 <= '0;
                r_f2 <= 1'b0;
            end else begin
                r_q1 <= w_ix[IW-1 -: 2];
                r_a1 <= w_ix[AW-1:0];
                r_q2 <= r_q1;
                r_f2 <= (r_q1 == Q1 || r_q1 == Q3) && r_a1 == '0;
            end
        end
        sine_qlut #(.N(N), .OUT_W(OUT_W)) u_lut (
            .clk  (clk),
            .addr (w_addr),
            .data (w_lut)
        );
        // The peak (a==0 in a falling quadrant) lies one entry past the quarter table
        assign w_s    = r_f2 ? FULL : $signed({1'b0, w_lut});
        assign w_o[c] = (r_q2 == Q2 || r_q2 == Q3) ? -w_s : w_s;
    end

`ifdef DPSG_AMP2_SCALE_EN
    logic [7:0]               r_amp;
    logic [7:0]               r_amp_p;
    logic [7:0]               r_g1;
    logic [7:0]               r_g2;
    logic signed [OUT_W+8:0]  w_prod;
    assign w_prod = (OUT_W+9)'($signed(w_o[1])) * (OUT_W+9)'($signed({1'b0, r_g2}));
    assign w_s2   = w_prod[OUT_W+7:8];
    // Gain travels down the pipe with its sample so a frame never mixes gains
    always_ff @(posedge clk) begin
        if (rst) begin
            r_amp   <= 8'd255;
            r_amp_p <= 8'd255;
            r_g1    <= 8'd255;
            r_g2    <= 8'd255;
        end else begin
            if (w_apply) r_amp <= r_amp_p;
            else if (cfg_valid && cfg_ready) r_amp_p <= cfg_amp2;
            r_g1 <= r_amp;
            r_g2 <= r_g1;
        end
    end
`else
    assign w_s2 = w_o[1];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_phase      <= '0;
            r_pend       <= '0;
            r_pend_v     <= 1'b0;
            r_applied    <= 1'b0;
            r_v1         <= 1'b0;
            r_v2         <= 1'b0;
            r_t1         <= 1'b0;
            r_t2         <= 1'b0;
            signal_1     <= '0;
            signal_2     <= '0;
            sample_valid <= 1'b0;
            frame_start  <= 1'b0;
        end else begin
            if (en) r_idx <= r_idx + IW'(1);
            r_applied <= w_apply;
            if (w_apply) begin
                r_phase  <= r_pend;
                r_pend_v <= 1'b0;
            end else if (cfg_valid && cfg_ready) begin
                r_pend   <= cfg_phase;
                r_pend_v <= 1'b1;
            end
            r_v1         <= en;
            r_t1         <= r_idx == '0;
            r_v2         <= r_v1;
            r_t2         <= r_t1;
            sample_valid <= r_v2;
            frame_start  <= r_v2 && r_t2;
            if (r_v2) begin
                signal_1 <= w_o[0];
                signal_2 <= w_s2;
            end
        end
    end
endmodule

// File: tb/tb_dual_phase_sig_gen.sv
// tb_dual_phase_sig_gen: vector table, corner sequences and random traffic against a sample-level model
module tb_dual_phase_sig_gen;
    localparam int  N    = 1024;
    localparam int  FULL = 2047;
    localparam real PI   = 3.141592653589793;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               en = 1'b0;
    logic signed [15:0] cfg_phase = '0;
    logic               cfg_valid = 1'b0;
`ifdef DPSG_AMP2_SCALE_EN
    logic [7:0]         cfg_amp2 = 8'd255;
`endif
    logic               cfg_ready;
    logic signed [11:0] signal_1;
    logic signed [11:0] signal_2;
    logic               sample_valid;
    logic               frame_start;

    dual_phase_sig_gen #(.N(N), .OUT_W(12), .PH_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_phase    (cfg_phase),
        .cfg_valid    (cfg_valid),
`ifdef DPSG_AMP2_SCALE_EN
        .cfg_amp2     (cfg_amp2),
`endif
        .cfg_ready    (cfg_ready),
        .signal_1     (signal_1),
        .signal_2     (signal_2),
        .sample_valid (sample_valid),
        .frame_start  (frame_start)
    );

    always #5 clk = ~clk;

    typedef struct { bit v; bit tag; int s1; int s2; } ent_t;
    typedef struct { int ph; int k; int s1; int s2; } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    ent_t d0, d1;
    int   m_idx, m_phase, m_pend, m_gain, m_pend_gain;
    bit   m_pend_v, m_hold, m_acc;
    int   e_s1, e_s2;
    bit   e_sv, e_fs, e_rdy;
    vec_t vt [8];

    function automatic int ref_sin(input int i);
        real s = FULL * $sin(2.0 * PI * i / N);
        return s >= 0.0 ? $rtoi(s + 0.5) : -$rtoi(0.5 - s);
    endfunction

    function automatic int ref_off(input int ph);
        int t = ph * N;
        int q = t >= 0 ? t / 32768 : -((32767 - t) / 32768);
        return ((q % N) + N) % N;
    endfunction

    function automatic int sc(input int s, input int g);
`ifdef DPSG_AMP2_SCALE_EN
        return $rtoi($floor(real'(s * g) / 256.0));
`else
        return s + 0 * g;
`endif
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock using the inputs currently applied
    task automatic model_edge();
        bit app;
        m_acc = 1'b0;
        if (rst) begin
            m_idx = 0; m_phase = 0; m_pend_v = 0; m_hold = 0;
            m_gain = 255; m_pend_gain = 255;
            d0 = '{default: 0};
            d1 = '{default: 0};
            e_s1 = 0; e_s2 = 0; e_sv = 0; e_fs = 0; e_rdy = 1;
            return;
        end
        m_acc = cfg_valid && e_rdy;
        app   = m_pend_v && (!en || m_idx == N - 1);
        e_sv  = d1.v;
        e_fs  = d1.v && d1.tag;
        if (d1.v) begin
            e_s1 = d1.s1;
            e_s2 = d1.s2;
        end
        d1     = d0;
        d0.v   = en;
        d0.tag = m_idx == 0;
        d0.s1  = ref_sin(m_idx);
        d0.s2  = sc(ref_sin((m_idx + ref_off(m_phase)) % N), m_gain);
        m_hold = app;
        if (app) begin
            m_phase  = m_pend;
            m_gain   = m_pend_gain;
            m_pend_v = 0;
        end else if (m_acc) begin
            m_pend   = int'(cfg_phase);
`ifdef DPSG_AMP2_SCALE_EN
            m_pend_gain = int'(cfg_amp2);
`endif
            m_pend_v = 1;
        end
        if (en) m_idx = (m_idx + 1) % N;
        e_rdy = !m_pend_v && !m_hold;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        chk("signal_1", int'(signal_1), e_s1);
        chk("signal_2", int'(signal_2), e_s2);
        chk("sample_valid", int'(sample_valid), int'(e_sv));
        chk("frame_start", int'(frame_start), int'(e_fs));
        chk("cfg_ready", int'(cfg_ready), int'(e_rdy));
    endtask

    task automatic do_reset();
        rst = 1'b1; en = 1'b0; cfg_valid = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_frame(output bit ok);
        ok = 1'b0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            tick();
            ok = frame_start;
        end
    endtask

    task automatic wait_valids(input int k, output bit ok);
        int c = 0;
        ok = k == 0;
        for (int t = 0; t < 3000 && !ok; t++) begin
            tick();
            if (sample_valid) c++;
            ok = c == k;
        end
    endtask

    task automatic load_phase(input int ph);
        cfg_phase = 16'(ph); cfg_valid = 1'b1; en = 1'b0;
        tick();
        cfg_valid = 1'b0;
        tick();
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        bit ok;
        vt[0] = '{0, 256, 2047, 2047};
        vt[1] = '{0, 768, -2047, -2047};
        vt[2] = '{8192, 0, 0, 2047};
        vt[3] = '{-8192, 0, 0, -2047};
        vt[4] = '{4096, 0, 0, 1447};
        vt[5] = '{8192, 256, 2047, 0};
        vt[6] = '{-16384, 256, 2047, -2047};
        vt[7] = '{0, 512, 0, 0};

        // Reset state and first-sample latency
        do_reset();
        chk("rst_signal_1", int'(signal_1), 0);
        chk("rst_signal_2", int'(signal_2), 0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        en = 1'b1;
        tick(); chk("lat_c1_valid", int'(sample_valid), 0);
        tick(); chk("lat_c2_valid", int'(sample_valid), 0);
        tick(); chk("lat_c3_valid", int'(sample_valid), 1);
        chk("lat_frame_start", int'(frame_start), 1);
        chk("lat_signal_1", int'(signal_1), 0);
        chk("lat_signal_2", int'(signal_2), 0);

        foreach (vt[i]) begin
            do_reset();
            load_phase(vt[i].ph);
            en = 1'b1;
            wait_frame(ok);
            chk("tab_frame_seen", int'(ok), 1);
            wait_valids(vt[i].k, ok);
            chk("tab_sample_seen", int'(ok), 1);
            chk($sformatf("tab%0d_signal_1", i), int'(signal_1), vt[i].s1);
            chk($sformatf("tab%0d_signal_2", i), int'(signal_2), sc(vt[i].s2, 255));
        end

        // Mid-frame update: old offset until the wrap, new offset from the next frame
        do_reset();
        en = 1'b1;
        for (int t = 0; t < 200 && m_idx != 100; t++) tick();
        cfg_phase = 16'sd4096; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        chk("mid_ready_low", int'(cfg_ready), 0);
        ok = 1'b0;
        for (int t = 0; t < 1500 && !ok; t++) begin
            tick();
            ok = frame_start;
            if (sample_valid && !frame_start) chk("mid_old_offset", int'(signal_2), sc(int'(signal_1), 255));
        end
        chk("mid_frame_seen", int'(ok), 1);
        chk("mid_new_signal_1", int'(signal_1), 0);
        chk("mid_new_signal_2", int'(signal_2), sc(1447, 255));
        chk("mid_ready_back", int'(cfg_ready), 1);

        // Reset with a word still pending discards it
        do_reset();
        en = 1'b1;
        for (int t = 0; t < 50; t++) tick();
        cfg_phase = 16'sd8192; cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstp_signal_1", int'(signal_1), 0);
        chk("rstp_signal_2", int'(signal_2), 0);
        chk("rstp_ready", int'(cfg_ready), 1);
        wait_frame(ok);
        wait_valids(256, ok);
        chk("rstp_signal_2_unshifted", int'(signal_2), sc(2047, 255));

`ifdef DPSG_AMP2_SCALE_EN
        do_reset();
        cfg_amp2 = 8'd128;
        load_phase(0);
        cfg_amp2 = 8'd255;
        en = 1'b1;
        wait_frame(ok);
        wait_valids(256, ok);
        chk("amp_peak", int'(signal_2), 1023);
        wait_valids(512, ok);
        chk("amp_trough", int'(signal_2), -1024);
`endif

        // Random traffic: bursty en, held cfg offers, rare resets
        do_reset();
        for (int t = 0; t < 20000; t++) begin
            rst = $urandom_range(0, 2999) == 0;
            en  = ((t / 2000) % 2 == 1) ? 1'b1 : ($urandom_range(0, 9) < 7);
            if (!cfg_valid && $urandom_range(0, 149) == 0) begin
                cfg_valid = 1'b1;
                cfg_phase = 16'($urandom);
`ifdef DPSG_AMP2_SCALE_EN
                cfg_amp2 = 8'($urandom);
`endif
            end
            tick();
            if (m_acc) cfg_valid = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
